// File: rtl/chacha_pkg.sv
// Shared constants, state-word layout and FSM encoding for the ChaCha20 stream XOR block.
// Also holds the rotate helper and the initial-state builder used by the datapath.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam int W_SIGMA = 0;
  localparam int W_KEY   = 4;
  localparam int W_CTR   = 12;
  localparam int W_NONCE = 13;

  localparam logic [3:0] DROUNDS = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEN    = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Word i of the state lives at bits [32*i +: 32]; key and nonce words are taken MSW first.
  function automatic logic [511:0] build_state(input logic [255:0] key,
                                               input logic [31:0]  ctr,
                                               input logic [95:0]  nonce);
    logic [511:0] s;
    s = '0;
    s[32*(W_SIGMA+0) +: 32] = SIGMA0;
    s[32*(W_SIGMA+1) +: 32] = SIGMA1;
    s[32*(W_SIGMA+2) +: 32] = SIGMA2;
    s[32*(W_SIGMA+3) +: 32] = SIGMA3;
    for (int j = 0; j < 8; j++) s[32*(W_KEY+j) +: 32] = key[255-32*j -: 32];
    s[32*W_CTR +: 32] = ctr;
    for (int j = 0; j < 3; j++) s[32*(W_NONCE+j) +: 32] = nonce[95-32*j -: 32];
    return s;
  endfunction

endpackage

// File: rtl/chacha_dround.sv
// Combinational ChaCha double round: four column quarter rounds followed by four diagonal ones.
module chacha_dround (
  input  logic [511:0] st_i,
  output logic [511:0] st_o
);

  logic [15:0][31:0] x, y, z;

  assign x    = st_i;
  assign st_o = z;

  for (genvar i = 0; i < 4; i++) begin : g_col
    chacha_quarterround u_qr (
      .a_i(x[i]),    .b_i(x[i+4]),  .c_i(x[i+8]),  .d_i(x[i+12]),
      .a_o(y[i]),    .b_o(y[i+4]),  .c_o(y[i+8]),  .d_o(y[i+12])
    );
  end

  // Diagonal i starts at word i and steps one column right per row, wrapping.
  for (genvar i = 0; i < 4; i++) begin : g_diag
    chacha_quarterround u_qr (
      .a_i(y[i]), .b_i(y[4+(i+1)%4]), .c_i(y[8+(i+2)%4]), .d_i(y[12+(i+3)%4]),
      .a_o(z[i]), .b_o(z[4+(i+1)%4]), .c_o(z[8+(i+2)%4]), .d_o(z[12+(i+3)%4])
    );
  end

endmodule

// File: rtl/chacha_quarterround.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_quarterround
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] a1, b1, c1, d1;

  always_comb begin
    a1  = a_i + b_i;
    d1  = rotl(d_i ^ a1, 16);
    c1  = c_i + d1;
    b1  = rotl(b_i ^ c1, 12);
    a_o = a1 + b1;
    d_o = rotl(d1 ^ a_o, 8);
    c_o = c1 + d_o;
    b_o = rotl(b1 ^ c_o, 7);
  end

endmodule

// File: rtl/chacha20_stream_xor.sv
// ChaCha20 keystream generator XORed onto a 32-bit valid/ready stream.
// One double round per GEN cycle; a 16-word keystream buffer feeds the stream phase.
module chacha20_stream_xor
  import chacha_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  init_ctr,
  input  logic         start,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         ctr_err
);

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic [3:0]   widx_q;
  logic [255:0] key_q;
  logic [95:0]  nonce_q;
  logic [31:0]  ctr_q;
  logic [511:0] st_q;
  logic [511:0] ks_q;
  logic [511:0] st_rnd;
  logic [511:0] init_st;
  logic [31:0]  out_data_q;
  logic         out_valid_q;
  logic         out_last_q;
  logic         ctr_err_q;
  logic         acc;

  assign init_st = build_state(key_q, ctr_q, nonce_q);

  chacha_dround u_dround (
    .st_i(st_q),
    .st_o(st_rnd)
  );

  assign in_ready  = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
  assign acc       = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = acc && in_last;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign ctr_err   = ctr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      widx_q      <= '0;
      ctr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ctr_err_q   <= 1'b0;
    end else begin
      // Drain happens in any state; a new acceptance below overrides it.
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q   <= key;
            nonce_q <= nonce;
            ctr_q   <= init_ctr;
            widx_q  <= '0;
            rnd_q   <= '0;
            st_q    <= build_state(key, init_ctr, nonce);
            state_q <= ST_GEN;
          end
        end
        ST_GEN: begin
          if (rnd_q == DROUNDS) begin
            for (int i = 0; i < 16; i++)
              ks_q[32*i +: 32] <= st_q[32*i +: 32] + init_st[32*i +: 32];
            state_q <= ST_STREAM;
          end else begin
            st_q  <= st_rnd;
            rnd_q <= rnd_q + 4'd1;
          end
        end
        ST_STREAM: begin
          if (acc) begin
            out_data_q  <= in_data ^ ks_q[32*widx_q +: 32];
            out_valid_q <= 1'b1;
            out_last_q  <= in_last;
            widx_q      <= widx_q + 4'd1;
            if (in_last) begin
              state_q <= ST_IDLE;
            end else if (widx_q == 4'hF) begin
              // Counter wrap would reuse keystream, so stop instead.
              if (ctr_q == 32'hFFFF_FFFF) begin
                ctr_err_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                ctr_q   <= ctr_q + 32'd1;
                st_q    <= build_state(key_q, ctr_q + 32'd1, nonce_q);
                rnd_q   <= '0;
                state_q <= ST_GEN;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// Directed bench for chacha20_stream_xor: RFC 8439 block vector, multi-block round trip,
// backpressure, counter exhaustion, ignored start and mid-message reset.
module tb_chacha20_stream_xor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  init_ctr;
  logic         start;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         ctr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] din  [64];
  logic [31:0] dout [64];
  logic [31:0] pt   [64];
  logic [31:0] ct   [64];
  int acc_cnt, got_cnt, gen_cyc, done_cnt, stab_bad, last_bad;

  localparam logic [255:0] RFC_KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
  localparam logic [95:0]  RFC_NONCE = {32'h09000000, 32'h4a000000, 32'h00000000};
  localparam logic [255:0] ALT_KEY = {8{32'hdeadbeef}};
  localparam logic [255:0] K2 = {32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00,
                                 32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
  localparam logic [95:0]  N2 = {32'hcafef00d, 32'h00000007, 32'h12345678};

  chacha20_stream_xor dut (
    .clk(clk), .rst(rst), .key(key), .nonce(nonce), .init_ctr(init_ctr), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .ctr_err(ctr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rfc_word(input int i);
    case (i)
      0: return 32'he4e7f110;  1: return 32'h15593bd1;  2: return 32'h1fdd0f50;  3: return 32'hc47120a3;
      4: return 32'hc7f4d1c7;  5: return 32'h0368c033;  6: return 32'h9aaa2204;  7: return 32'h4e6cd4c3;
      8: return 32'h466482d2;  9: return 32'h09aa9f07; 10: return 32'h05d7c214; 11: return 32'ha2028bd9;
     12: return 32'hd19c12b5; 13: return 32'hb94e16de; 14: return 32'he883d0cb; default: return 32'h4e3c50a2;
    endcase
  endfunction

  function automatic logic [31:0] tb_rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // Reference block function: sequential quarter rounds over an array, driven by an index table.
  function automatic logic [511:0] model_block(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n);
    logic [31:0] s0 [16];
    logic [31:0] x  [16];
    logic [511:0] r;
    int q [8][4];
    int a, b, cc, d;
    q = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
          '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    s0[0] = 32'h61707865; s0[1] = 32'h3320646e; s0[2] = 32'h79622d32; s0[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s0[4+j] = k[255-32*j -: 32];
    s0[12] = c;
    for (int j = 0; j < 3; j++) s0[13+j] = n[95-32*j -: 32];
    x = s0;
    for (int rr = 0; rr < 10; rr++) begin
      for (int g = 0; g < 8; g++) begin
        a = q[g][0]; b = q[g][1]; cc = q[g][2]; d = q[g][3];
        x[a] = x[a] + x[b];   x[d] = tb_rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = tb_rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b];   x[d] = tb_rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = tb_rotl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s0[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_ks(input logic [255:0] k, input logic [31:0] c,
                                         input logic [95:0] n, input int i);
    logic [511:0] blk;
    blk = model_block(k, c + 32'(i / 16), n);
    return blk[32*(i % 16) +: 32];
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    key = k; init_ctr = c; nonce = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives din[0..n-1], collects outputs into dout, and records timing observations.
  task automatic run_msg(input int n, input bit last_on_final, input bit rand_bp,
                         input int budget, input bit poke);
    int idx, cyc;
    logic held_v;
    logic [31:0] held_d;
    bit poked5;
    idx = 0; cyc = 0; got_cnt = 0; gen_cyc = 0; done_cnt = 0; stab_bad = 0; last_bad = 0;
    held_v = 1'b0; held_d = '0; poked5 = 1'b0;
    while (got_cnt < n && cyc < budget) begin
      in_valid  = (idx < n);
      in_data   = (idx < n) ? din[idx] : 32'h0;
      in_last   = last_on_final && (idx == n - 1);
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke && ((idx == 5 && !poked5) || idx == n - 1);
      if (poke && idx == 5) poked5 = 1'b1;
      #1;
      if (held_v && (!out_valid || out_data !== held_d)) stab_bad++;
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (busy && !in_ready && !(out_valid && !out_ready)) gen_cyc++;
      if (done) done_cnt++;
      if (done && !(in_valid && in_ready && in_last)) last_bad++;
      if (out_valid && out_ready) begin
        if (got_cnt < 64) dout[got_cnt] = out_data;
        if (out_last !== (last_on_final && got_cnt == n - 1)) last_bad++;
        got_cnt++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0; out_ready = 1'b1;
    acc_cnt = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (ctr_err !== 1'b0) begin n_fail++; $display("FAIL rst_ctr_err: got %b want 0", ctr_err); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_rfc_vector();
    int errs, first;
    do_start(RFC_KEY, 32'd1, RFC_NONCE);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rfc_busy_c1: got %b want 1", busy); end
    for (int i = 0; i < 16; i++) din[i] = 32'h0;
    run_msg(16, 1'b1, 1'b0, 200, 1'b0);
    n_checks++; if (got_cnt != 16) begin n_fail++; $display("FAIL rfc_count: got %0d want 16", got_cnt); end
    n_checks++; if (gen_cyc != 11) begin n_fail++; $display("FAIL rfc_gen_cycles: got %0d want 11", gen_cyc); end
    n_checks++; if (dout[0] !== 32'he4e7f110) begin n_fail++; $display("FAIL rfc_word0: got %h want e4e7f110", dout[0]); end
    n_checks++; if (dout[1] !== 32'h15593bd1) begin n_fail++; $display("FAIL rfc_word1: got %h want 15593bd1", dout[1]); end
    errs = 0; first = 0;
    for (int i = 0; i < 16; i++) if (dout[i] !== rfc_word(i)) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL rfc_block: %0d words differ, word %0d got %h want %h", errs, first, dout[first], rfc_word(first)); end
    n_checks++; if (done_cnt != 1 || last_bad != 0) begin n_fail++; $display("FAIL rfc_done_last: done pulses %0d last errors %0d want 1 and 0", done_cnt, last_bad); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rfc_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_enc_dec();
    int errs, first;
    logic [31:0] want;
    for (int i = 0; i < 37; i++) begin pt[i] = $urandom; din[i] = pt[i]; end
    do_start(K2, 32'd1, N2);
    run_msg(37, 1'b1, 1'b0, 400, 1'b0);
    for (int i = 0; i < 37; i++) ct[i] = dout[i];
    n_checks++; if (got_cnt != 37) begin n_fail++; $display("FAIL enc_count: got %0d want 37", got_cnt); end
    n_checks++; if (gen_cyc != 33) begin n_fail++; $display("FAIL enc_gen_cycles: got %0d want 33", gen_cyc); end
    n_checks++; if (done_cnt != 1 || last_bad != 0) begin n_fail++; $display("FAIL enc_done_last: done pulses %0d last errors %0d want 1 and 0", done_cnt, last_bad); end
    want = pt[32] ^ exp_ks(K2, 32'd3, N2, 0);
    n_checks++; if (ct[32] !== want) begin n_fail++; $display("FAIL enc_ctr3_word: got %h want %h", ct[32], want); end
    errs = 0; first = 0;
    for (int i = 0; i < 37; i++) if (ct[i] !== (pt[i] ^ exp_ks(K2, 32'd1, N2, i))) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL enc_words: %0d words differ, first at %0d got %h", errs, first, ct[first]); end
    for (int i = 0; i < 37; i++) din[i] = ct[i];
    do_start(K2, 32'd1, N2);
    run_msg(37, 1'b1, 1'b0, 400, 1'b0);
    errs = 0; first = 0;
    for (int i = 0; i < 37; i++) if (dout[i] !== pt[i]) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0 || got_cnt != 37) begin n_fail++; $display("FAIL dec_roundtrip: %0d words differ (count %0d), first at %0d got %h want %h", errs, got_cnt, first, dout[first], pt[first]); end
  endtask

  task automatic test_backpressure();
    int errs, first;
    for (int i = 0; i < 40; i++) din[i] = $urandom;
    do_start(RFC_KEY, 32'd5, RFC_NONCE);
    run_msg(40, 1'b1, 1'b1, 2000, 1'b0);
    n_checks++; if (got_cnt != 40) begin n_fail++; $display("FAIL bp_count: got %0d want 40", got_cnt); end
    n_checks++; if (stab_bad != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalls want 0", stab_bad); end
    errs = 0; first = 0;
    for (int i = 0; i < 40; i++) if (dout[i] !== (din[i] ^ exp_ks(RFC_KEY, 32'd5, RFC_NONCE, i))) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL bp_words: %0d words differ, first at %0d got %h", errs, first, dout[first]); end
    n_checks++; if (done_cnt != 1 || last_bad != 0) begin n_fail++; $display("FAIL bp_done_last: done pulses %0d last errors %0d want 1 and 0", done_cnt, last_bad); end
  endtask

  task automatic test_start_ignored();
    int errs, first;
    do_start(RFC_KEY, 32'd1, RFC_NONCE);
    key = ALT_KEY;
    for (int i = 0; i < 16; i++) din[i] = 32'h0;
    run_msg(16, 1'b1, 1'b0, 200, 1'b1);
    errs = 0; first = 0;
    for (int i = 0; i < 16; i++) if (dout[i] !== rfc_word(i)) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0 || got_cnt != 16) begin n_fail++; $display("FAIL start_ign_words: %0d words differ (count %0d), word %0d got %h want %h", errs, got_cnt, first, dout[first], rfc_word(first)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_ign_at_done: busy %b want 0", busy); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL start_ign_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int errs, first;
    do_start(RFC_KEY, 32'd1, RFC_NONCE);
    for (int i = 0; i < 16; i++) din[i] = 32'h0;
    run_msg(7, 1'b0, 1'b0, 100, 1'b0);
    n_checks++; if (got_cnt != 7 || dout[6] !== rfc_word(6)) begin n_fail++; $display("FAIL mid_pre: count %0d word6 %h want 7 and %h", got_cnt, dout[6], rfc_word(6)); end
    in_valid = 1'b1; in_data = 32'h5a5a5a5a; out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: valid %b data %h last %b want 0 0 0", out_valid, out_data, out_last); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ctr_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: in_ready %b busy %b done %b ctr_err %b want all 0", in_ready, busy, done, ctr_err); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    do_start(RFC_KEY, 32'd1, RFC_NONCE);
    run_msg(16, 1'b1, 1'b0, 200, 1'b0);
    errs = 0; first = 0;
    for (int i = 0; i < 16; i++) if (dout[i] !== rfc_word(i)) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0 || got_cnt != 16) begin n_fail++; $display("FAIL mid_restart: %0d words differ (count %0d), word %0d got %h want %h", errs, got_cnt, first, dout[first], rfc_word(first)); end
  endtask

  task automatic test_ctr_exhaust();
    int errs, first, hi;
    apply_reset();
    for (int i = 0; i < 20; i++) din[i] = $urandom;
    do_start(RFC_KEY, 32'hFFFF_FFFF, RFC_NONCE);
    run_msg(20, 1'b0, 1'b0, 80, 1'b0);
    n_checks++; if (acc_cnt != 16 || got_cnt != 16) begin n_fail++; $display("FAIL exh_count: accepted %0d output %0d want 16 16", acc_cnt, got_cnt); end
    errs = 0; first = 0;
    for (int i = 0; i < 16; i++) if (dout[i] !== (din[i] ^ exp_ks(RFC_KEY, 32'hFFFF_FFFF, RFC_NONCE, i))) begin if (errs == 0) first = i; errs++; end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL exh_words: %0d words differ, first at %0d got %h", errs, first, dout[first]); end
    n_checks++; if (ctr_err !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin n_fail++; $display("FAIL exh_state: ctr_err %b busy %b done pulses %0d want 1 0 0", ctr_err, busy, done_cnt); end
    in_valid = 1'b1; hi = 0;
    for (int c = 0; c < 5; c++) begin #1; if (in_ready) hi++; @(negedge clk); end
    in_valid = 1'b0;
    n_checks++; if (hi != 0) begin n_fail++; $display("FAIL exh_in_ready: high %0d cycles want 0", hi); end
    apply_reset();
    do_start(RFC_KEY, 32'hFFFF_FFFF, RFC_NONCE);
    run_msg(16, 1'b1, 1'b0, 200, 1'b0);
    n_checks++; if (done_cnt != 1 || ctr_err !== 1'b0 || got_cnt != 16) begin n_fail++; $display("FAIL exh_last16: done pulses %0d ctr_err %b count %0d want 1 0 16", done_cnt, ctr_err, got_cnt); end
  endtask

  initial begin
    rst = 1'b1; key = '0; nonce = '0; init_ctr = '0; start = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    test_reset();
    test_rfc_vector();
    test_enc_dec();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_ctr_exhaust();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chacha20_stream_xor.md
# chacha20_stream_xor

Keystream consumer for the ChaCha20 datapath. It builds the 16-word ChaCha20 state from key, nonce and block counter, and generates one 512-bit keystream block at a time with an iterative double-round core. It XORs that keystream word-by-word onto a 32-bit valid/ready data stream. Because the XOR is symmetric, the same block performs both encryption and decryption, and it sits between the message buffer and the memory write path.

## Interface
- No parameters. Data width is fixed at 32 and the number of double rounds is fixed at 10.
- clk  in  1  system clock; all logic runs on the rising edge
- rst  in  1  synchronous, active-high reset
- key  in  256  key; key[255:224] is state word 4 and key[31:0] is word 11; sampled on an accepted start
- nonce  in  96  nonce; nonce[95:64] is word 13; sampled on an accepted start
- init_ctr  in  32  initial block counter (word 12); sampled on an accepted start
- start  in  1  one-cycle request; ignored unless in IDLE
- in_data  in  32  plaintext or ciphertext word
- in_valid  in  1  input word valid
- in_last  in  1  marks the final word of the message
- in_ready  out  1  input word accepted when in_valid && in_ready
- out_data  out  32  in_data XOR keystream word
- out_valid  out  1  output word valid
- out_last  out  1  copy of in_last for the corresponding word
- out_ready  in  1  downstream accepts the output when out_valid && out_ready
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when the last word is accepted at the input
- ctr_err  out  1  sticky flag set on block-counter exhaustion; cleared only by rst

## Operation
- State words 0–3 are the constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4–11 are key, word 12 is ctr, words 13–15 are nonce.
- All words are used as given, with no byte swapping. Any endianness conversion is the caller's job.
- FSM states are IDLE, GEN and STREAM.
- IDLE → GEN on start: latch key, nonce and init_ctr; clear the word index.
- GEN runs 10 cycles, one double round per cycle (column round, then diagonal round).
- On the 11th GEN cycle, the feed-forward sum of round output and the initial state (mod 2^32 per word) is written into the 16×32 keystream buffer, then the FSM moves to STREAM.
- In STREAM, in_ready = !out_valid || out_ready.
- Each accepted word produces out_data = in_data ^ ks[widx] and increments widx (4 bits).
- Words are consumed in order ks[0]..ks[15]; ks[0] is feed-forward state word 0.
- Accepting a word with in_last set → pulse done, return to IDLE. Unused keystream is discarded.
- Accepting word 15 without in_last → ctr <= ctr+1, widx wraps to 0, FSM enters GEN.
- Counter exhaustion: if word 15 is accepted without in_last while ctr == 0xFFFFFFFF, set ctr_err, go to IDLE and do not wrap the counter.
- in_last on word 15 takes priority: done pulses and ctr_err is not set.
- start outside IDLE is ignored, including start in the same cycle that done fires.
- Outputs already held in the output register drain normally in IDLE.
- Reset values: in_ready, out_valid, out_last, busy, done and ctr_err are 0; out_data is 0. The FSM goes to IDLE, ctr and widx clear, and the buffer contents are don't-care.
- Reset mid-message aborts the message with no done pulse.

## Timing
- Start accepted at cycle 0 → GEN in cycles 1–11 → first in_ready in cycle 12.
- Input to output latency is 1 cycle: out_data, out_valid and out_last are registered.
- Throughput is 1 word/cycle while STREAM holds and out_ready stays high.
- Each block boundary inserts an 11-cycle GEN gap with in_ready low.
- out_valid stays high and out_data stays stable until out_ready. in_ready is low while the output is stalled.
- busy rises in cycle 1 and falls the cycle after the last word is accepted.

## Structure
- Package chacha_pkg holds:
  - the four sigma constants
  - the state word index map
  - the FSM state enum
  - the double-round count of 10
- One sub-module, chacha_dround: a combinational double round (16×32 in, 16×32 out) built from the existing chacha_quarterround, with 8 instances.
- The top level holds the FSM, round counter, state register, buffer, counter and output register.

## Test plan
- RFC 8439 §2.3.2 vector: key bytes 00..1f, nonce 000000090000004a00000000, ctr=1, all words formed little-endian, in_data=0 for 16 words → out_data word0 = 0xe4e7f110, word1 = 0x15593bd1, and all 16 words match the RFC state output.
- Encrypt then decrypt a 37-word random message with identical key, nonce and ctr → recovered data equals the original. Check two GEN gaps of 11 cycles, done on word 37, and ctr advancing 1→3.
- Random out_ready backpressure at 50% over 40 words → no data loss or duplication, and out_data stays stable while stalled.
- init_ctr = 0xFFFFFFFF, 20 words with no last → words 0–15 are correct, then ctr_err=1, the FSM returns to IDLE and in_ready stays low. Repeat with in_last on word 16 → done=1 and ctr_err=0.
- start pulsed during STREAM with a different key → ignored, and the output keystream is unchanged.
- rst asserted after 7 words → next cycle all outputs are 0 and the FSM is in IDLE. A fresh start then reproduces the vector above from word 0.
